counter_b4_seq: RTL and testbench
=================================

// Module: counter_b4_seq
// PURPOSE
// - Command sequencer directly upstream of the 4-bit mode counter; produces its b4_enable/b4_mode/b4_D.
// - Buffers commands {mode, data, len} in a small FIFO and plays each one to the counter for len+1 cycles.
// - Plays commands back to back; reports per-command completion and the number of RCO cycles seen.
// PARAMETERS
// - FIFO_DEPTH  4  command FIFO entries (power of two, >=2)
// - LEN_W       4  width of cmd_len; a command lasts cmd_len+1 cycles (1..2**LEN_W)
// PORTS
// - b4_clk        in   1      single clock, all logic on posedge
// - b4_reset_n    in   1      asynchronous, active-low reset
// - cmd_valid     in   1      command offered
// - cmd_ready     out  1      FIFO can accept (= !full)
// - cmd_mode      in   2      00 up, 01 down, 10 down-by-3, 11 parallel load
// - cmd_data      in   4      load value (used only when cmd_mode=11)
// - cmd_len       in   LEN_W  run length minus one
// - abort         in   1      flush FIFO and stop the current command
// - b4_enable     out  1      counter enable
// - b4_mode       out  2      counter mode
// - b4_D          out  4      counter parallel data
// - b4_rco        in   1      counter ripple-carry out, sampled on posedge
// - busy          out  1      1 while in RUN
// - done          out  1      1-cycle pulse when a command finishes (not on abort)
// - done_rco      out  8      RCO-high cycles during the finished command (saturating)
// BEHAVIOUR
// - Reset (async, b4_reset_n=0): FIFO empty, state IDLE, b4_enable=0, b4_mode=00, b4_D=0,
//   busy=0, done=0, done_rco=0, cmd_ready=1. All outputs are registered except cmd_ready.
// - Accept: handshake when cmd_valid&&cmd_ready at a posedge. cmd_ready=0 only when full;
//   a push and a pop in the same cycle when full is not allowed (ready is already low).
// - FSM states: IDLE, RUN.
//   IDLE: b4_enable=0, busy=0. If FIFO is non-empty, pop the head, load len_cnt=cmd_len,
//     drive b4_enable=1, b4_mode, b4_D from the head, clear rco_acc, and go to RUN.
//   RUN: hold the outputs and decrement len_cnt each cycle. When len_cnt==0:
//     pulse done and latch done_rco = rco_acc plus the current b4_rco.
//     If the FIFO is non-empty, pop the next command in the same edge with no gap cycle
//       (b4_enable stays 1); otherwise go to IDLE with b4_enable=0.
// - Mode 11 commands always last exactly 1 cycle: cmd_len is ignored and len_cnt is forced to 0.
// - Latency: a command accepted at edge k into an empty, idle sequencer drives b4_enable=1
//   from edge k+1, so it is visible in the cycle after the accept cycle.
// - rco_acc: counts cycles in RUN with b4_rco=1, saturates at 255, cleared on every pop.
// - abort (sampled on posedge, priority over everything except reset): FIFO emptied,
//   state->IDLE, b4_enable=0, no done pulse. A push in the same cycle is discarded.
// - Wrap-around: FIFO pointers are log2(FIFO_DEPTH)+1 bits. Full when the MSBs differ and
//   the rest are equal; empty when the pointers are equal. len_cnt never underflows.
// - Reset mid-command: everything returns to the reset values immediately. No done pulse.
// STRUCTURE
// - Package counter_b4_pkg: localparams MODE_UP=2'b00, MODE_DN=2'b01, MODE_DN3=2'b10,
//   MODE_LD=2'b11; state encoding ST_IDLE/ST_RUN; CMD_W=2+4+LEN_W.
// - One sub-module: counter_b4_cmd_fifo (sync FIFO, params DEPTH/WIDTH, async active-low
//   reset, push/pop/full/empty/head). The top module holds the FSM, len_cnt and rco_acc.
// TESTING
// - Single cmd {00,x,len=3} after reset -> b4_enable=1, b4_mode=00 for exactly 4 cycles,
//   then done=1 for 1 cycle and b4_enable=0.
// - Load {11,D=4'hA,len=7} -> exactly 1 enable cycle with b4_mode=11 and b4_D=A, then done.
// - Push 4 commands with no gap (DEPTH=4) -> cmd_ready low only while 4 entries are held;
//   the commands play back to back with no b4_enable=0 cycle and give 4 done pulses.
// - Hold b4_rco=1 for 2 of the 6 cycles of a {00,len=5} command -> done_rco=2;
//   a 16-cycle command with b4_rco stuck at 1 -> done_rco=16.
// - abort in the 2nd cycle of {01,len=9} with 2 commands queued -> b4_enable=0 next cycle,
//   no done pulse, FIFO empty, cmd_ready=1.
// - Drive b4_reset_n low mid-RUN -> all outputs go to their reset values asynchronously;
//   after release the sequencer stays idle until a new command is accepted.

Source files
------------

// File: rtl/counter_b4_pkg.sv
// Shared constants, state encoding and helpers for the counter_b4 sequencer.
// Mode codes match the 4-bit mode counter it drives.
package counter_b4_pkg;

    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_LEN_W      = 4;
    localparam int CMD_W          = 2 + 4 + DEF_LEN_W;

    localparam logic [1:0] MODE_UP  = 2'b00;
    localparam logic [1:0] MODE_DN  = 2'b01;
    localparam logic [1:0] MODE_DN3 = 2'b10;
    localparam logic [1:0] MODE_LD  = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] a, input logic b);
        return (b && (a != 8'hFF)) ? a + 8'd1 : a;
    endfunction

endpackage

// File: rtl/counter_b4_cmd_fifo.sv
// Synchronous command FIFO with wrap-bit pointers and a flush input.
// Head is combinational from storage; storage itself is not reset.
module counter_b4_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + 1'b1;
            if (pop_i)  rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_q[AW-1:0]] <= data_i;
    end

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head_o  = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/counter_b4_seq.sv
// Command sequencer feeding the 4-bit mode counter: queues {mode,data,len}
// and plays each for len+1 cycles back to back, counting RCO cycles.
module counter_b4_seq
    import counter_b4_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int LEN_W      = DEF_LEN_W
) (
    input  logic             b4_clk,
    input  logic             b4_reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [3:0]       cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             abort,
    output logic             b4_enable,
    output logic [1:0]       b4_mode,
    output logic [3:0]       b4_D,
    input  logic             b4_rco,
    output logic             busy,
    output logic             done,
    output logic [7:0]       done_rco
);

    localparam int CW = 2 + 4 + LEN_W;
    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [7:0]       rco_acc_q, rco_acc_d;
    logic             en_q, en_d;
    logic [1:0]       mode_q, mode_d;
    logic [3:0]       data_q, data_d;
    logic             done_q, done_d;
    logic [7:0]       drco_q, drco_d;

    logic             full, empty, push, pop;
    logic [CW-1:0]    head;
    logic [1:0]       h_mode;
    logic [3:0]       h_data;
    logic [LEN_W-1:0] h_len;
    logic [7:0]       rco_inc;

    // Pushes are dropped during abort; the flush wins over everything else.
    assign push = cmd_valid && !full && !abort;

    counter_b4_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CW)
    ) u_fifo (
        .clk_i   (b4_clk),
        .rst_ni  (b4_reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (abort),
        .data_i  ({cmd_mode, cmd_data, cmd_len}),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

    assign h_mode  = head[CW-1 -: 2];
    assign h_data  = head[LEN_W +: 4];
    assign h_len   = head[LEN_W-1:0];
    assign rco_inc = sat_inc8(rco_acc_q, b4_rco);

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        rco_acc_d = rco_acc_q;
        en_d      = en_q;
        mode_d    = mode_q;
        data_d    = data_q;
        done_d    = 1'b0;
        drco_d    = drco_q;
        pop       = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
            en_d    = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!empty) pop = 1'b1;
                end
                ST_RUN: begin
                    rco_acc_d = rco_inc;
                    if (len_q == '0) begin
                        done_d = 1'b1;
                        drco_d = rco_inc;
                        if (!empty) begin
                            pop = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            en_d    = 1'b0;
                        end
                    end else begin
                        len_d = len_q - LEN_ONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // A pop starts the head command on this edge, with no gap cycle.
        if (pop) begin
            state_d   = ST_RUN;
            en_d      = 1'b1;
            mode_d    = h_mode;
            data_d    = h_data;
            len_d     = (h_mode == MODE_LD) ? '0 : h_len;
            rco_acc_d = '0;
        end
    end

    always_ff @(posedge b4_clk or negedge b4_reset_n) begin
        if (!b4_reset_n) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            rco_acc_q <= '0;
            en_q      <= 1'b0;
            mode_q    <= MODE_UP;
            data_q    <= '0;
            done_q    <= 1'b0;
            drco_q    <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            rco_acc_q <= rco_acc_d;
            en_q      <= en_d;
            mode_q    <= mode_d;
            data_q    <= data_d;
            done_q    <= done_d;
            drco_q    <= drco_d;
        end
    end

    assign cmd_ready = !full;
    assign b4_enable = en_q;
    assign b4_mode   = mode_q;
    assign b4_D      = data_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = done_q;
    assign done_rco  = drco_q;

endmodule

// File: tb/tb_counter_b4_seq.sv
// Bench for counter_b4_seq: queue-based command model checked every cycle,
// plus directed scenarios pinned with hand-computed literal values.
module tb_counter_b4_seq;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, abort, b4_enable, b4_rco, busy, done;
    logic [1:0] cmd_mode, b4_mode;
    logic [3:0] cmd_data, cmd_len, b4_D;
    logic [7:0] done_rco;

    always #5 clk = ~clk;

    counter_b4_seq dut (
        .b4_clk     (clk),
        .b4_reset_n (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_data   (cmd_data),
        .cmd_len    (cmd_len),
        .abort      (abort),
        .b4_enable  (b4_enable),
        .b4_mode    (b4_mode),
        .b4_D       (b4_D),
        .b4_rco     (b4_rco),
        .busy       (busy),
        .done       (done),
        .done_rco   (done_rco)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference model: a queue of pending commands and the one playing now.
    logic [9:0] q[$];
    bit         m_act  = 0;
    int         m_rem  = 0;
    int         m_rc   = 0;
    logic [1:0] m_mode = 0;
    logic [3:0] m_d    = 0;
    bit         m_done = 0;
    int         m_drco = 0;

    initial forever begin
        logic [9:0] c;
        bit         push_ok;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q.delete();
            m_act = 0; m_rem = 0; m_rc = 0;
            m_mode = 0; m_d = 0; m_done = 0; m_drco = 0;
        end else begin
            push_ok = cmd_valid && (q.size() < DEPTH);
            m_done  = 0;
            if (abort) begin
                q.delete();
                m_act = 0;
            end else begin
                if (m_act) begin
                    if (b4_rco && m_rc < 255) m_rc++;
                    m_rem--;
                    if (m_rem == 0) begin
                        m_done = 1;
                        m_drco = m_rc;
                        m_act  = 0;
                    end
                end
                if (!m_act && q.size() > 0) begin
                    c      = q.pop_front();
                    m_mode = c[9:8];
                    m_d    = c[7:4];
                    m_rem  = (c[9:8] == 2'b11) ? 1 : int'(c[3:0]) + 1;
                    m_rc   = 0;
                    m_act  = 1;
                end
                if (push_ok) q.push_back({cmd_mode, cmd_data, cmd_len});
            end
        end
    end

    // Per-cycle compare and simple observation counters.
    int en_cycles, done_cnt, full_cycles, gaps, last_rco;
    int last_mode, last_d;
    bit gap_arm;

    initial forever begin
        @(posedge clk);
        #1;
        chk("enable",   b4_enable, m_act);
        chk("busy",     busy,      m_act);
        chk("mode",     b4_mode,   m_mode);
        chk("data",     b4_D,      m_d);
        chk("done",     done,      m_done);
        chk("done_rco", done_rco,  m_drco);
        chk("ready",    cmd_ready, (q.size() < DEPTH) ? 1 : 0);
        if (rst_n) begin
            if (gap_arm && !b4_enable && !done && done_cnt < 5) gaps++;
            if (b4_enable) begin
                en_cycles++;
                last_mode = b4_mode;
                last_d    = b4_D;
            end
            if (done) begin
                done_cnt++;
                last_rco = done_rco;
            end
            if (!cmd_ready) full_cycles++;
        end
    end

    task automatic clr();
        en_cycles = 0; done_cnt = 0; full_cycles = 0;
        gaps = 0; gap_arm = 0; last_rco = 0;
    endtask

    task automatic send(input logic [1:0] m, input logic [3:0] d, input logic [3:0] l);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_mode = m; cmd_data = d; cmd_len = l; abort = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            cmd_valid = 1'b0; abort = 1'b0;
        end
    endtask

    task automatic wait_done(input int n, input int budget);
        int k = 0;
        while (done_cnt < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("wait_done_timeout", (done_cnt >= n) ? 1 : 0, 1);
    endtask

    initial begin
        int rgiven, k;
        rst_n = 1'b0; cmd_valid = 0; cmd_mode = 0; cmd_data = 0;
        cmd_len = 0; abort = 0; b4_rco = 0;
        clr();
        #1;
        chk("rst_ready",  cmd_ready, 1);
        chk("rst_enable", b4_enable, 0);
        chk("rst_busy",   busy, 0);
        chk("rst_drco",   done_rco, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Single count-up command, len=3 -> 4 enable cycles then done.
        clr();
        send(2'b00, 4'h0, 4'd3);
        idle(1);
        wait_done(1, 20);
        idle(2);
        chk("t1_en_cycles", en_cycles, 4);
        chk("t1_done_cnt",  done_cnt, 1);
        chk("t1_enable_off", b4_enable, 0);

        // Load ignores len: exactly one cycle with mode 11, D=A.
        clr();
        send(2'b11, 4'hA, 4'd7);
        idle(1);
        wait_done(1, 20);
        idle(2);
        chk("t2_en_cycles", en_cycles, 1);
        chk("t2_mode", last_mode, 3);
        chk("t2_data", last_d, 10);
        chk("t2_done_cnt", done_cnt, 1);

        // Long command holds the head while 4 more fill the FIFO.
        clr();
        send(2'b00, 4'h1, 4'd15);
        idle(1);
        send(2'b01, 4'h2, 4'd1);
        send(2'b10, 4'h3, 4'd2);
        send(2'b00, 4'h4, 4'd0);
        send(2'b11, 4'h5, 4'd3);
        idle(1);
        gap_arm = 1;
        wait_done(5, 100);
        idle(2);
        chk("t3_done_cnt", done_cnt, 5);
        chk("t3_gaps", gaps, 0);
        chk("t3_en_cycles", en_cycles, 23);
        chk("t3_full_cycles", full_cycles, 12);
        gap_arm = 0;

        // RCO high for 2 of 6 cycles.
        clr();
        send(2'b00, 4'h0, 4'd5);
        idle(1);
        rgiven = 0; k = 0;
        while (done_cnt < 1 && k < 30) begin
            @(negedge clk);
            b4_rco = b4_enable && (rgiven < 2);
            if (b4_rco) rgiven++;
            k++;
        end
        b4_rco = 1'b0;
        chk("t4_timeout", done_cnt, 1);
        chk("t4_drco", last_rco, 2);

        // RCO stuck high for a 16-cycle command.
        clr();
        b4_rco = 1'b1;
        send(2'b00, 4'h0, 4'd15);
        idle(1);
        wait_done(1, 40);
        b4_rco = 1'b0;
        chk("t5_drco", last_rco, 16);
        idle(2);

        // Abort in the second cycle with two commands queued.
        clr();
        send(2'b01, 4'h0, 4'd9);
        send(2'b00, 4'h1, 4'd2);
        send(2'b10, 4'h2, 4'd3);
        @(negedge clk);
        cmd_valid = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t6_enable", b4_enable, 0);
        chk("t6_busy", busy, 0);
        chk("t6_ready", cmd_ready, 1);
        idle(6);
        chk("t6_done_cnt", done_cnt, 0);
        chk("t6_en_cycles", en_cycles, 2);

        // Asynchronous reset in the middle of a command.
        clr();
        send(2'b01, 4'h5, 4'd9);
        idle(4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_enable", b4_enable, 0);
        chk("t7_busy", busy, 0);
        chk("t7_mode", b4_mode, 0);
        chk("t7_data", b4_D, 0);
        chk("t7_done", done, 0);
        chk("t7_drco", done_rco, 0);
        chk("t7_ready", cmd_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        clr();
        idle(6);
        chk("t7_idle_after", en_cycles, 0);

        // Random traffic against the model.
        repeat (500) begin
            @(negedge clk);
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_mode  = 2'($urandom_range(0, 3));
            cmd_data  = 4'($urandom_range(0, 15));
            cmd_len   = 4'($urandom_range(0, 15));
            b4_rco    = 1'($urandom_range(0, 1));
            abort     = ($urandom_range(0, 59) == 0);
        end
        b4_rco = 1'b0;
        idle(120);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
